// File: rtl/dom.sv
// LED pattern sequencer: prescaled step tick drives five display modes in a fixed cycle.
// Define DOM_ACTIVE_LOW_EN to drive inverted LEDs for active-low boards.
module dom #(
  parameter int DIV   = 25_000_000,
  parameter int STEPS = 16
) (
  input  logic       iCLK,
  input  logic       iRST,
  output logic [7:0] oLED
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

  typedef enum logic [2:0] {
    RUN_L  = 3'd0,
    RUN_R  = 3'd1,
    BOUNCE = 3'd2,
    COUNT  = 3'd3,
    BLINK  = 3'd4
  } modeT;

  logic [CW-1:0] cnt;
  logic [SW-1:0] step, stepNext;
  modeT          mode, modeNext;
  logic [7:0]    pat, patNext;
  logic [2:0]    pos, posNext;
  logic          up, upNext;
  logic          tick;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      step <= '0;
      mode <= RUN_L;
      pat  <= 8'h01;
      pos  <= 3'd0;
      up   <= 1'b1;
    end else begin
      step <= stepNext;
      mode <= modeNext;
      pat  <= patNext;
      pos  <= posNext;
      up   <= upNext;
    end
  end

  always_comb begin
    stepNext = step;
    modeNext = mode;
    patNext  = pat;
    posNext  = pos;
    upNext   = up;
    if (tick) begin
      if (mode > BLINK) begin
        // Unreachable encodings recover to the start of the sequence.
        stepNext = '0;
        modeNext = RUN_L;
        patNext  = 8'h01;
        posNext  = 3'd0;
        upNext   = 1'b1;
      end else if (step == STEP_LAST) begin
        stepNext = '0;
        posNext  = 3'd0;
        upNext   = 1'b1;
        case (mode)
          RUN_L:   begin modeNext = RUN_R;  patNext = 8'h80; end
          RUN_R:   begin modeNext = BOUNCE; patNext = 8'h01; end
          BOUNCE:  begin modeNext = COUNT;  patNext = 8'h00; end
          COUNT:   begin modeNext = BLINK;  patNext = 8'hAA; end
          default: begin modeNext = RUN_L;  patNext = 8'h01; end
        endcase
      end else begin
        stepNext = step + 1'b1;
        case (mode)
          RUN_L:  patNext = {pat[6:0], pat[7]};
          RUN_R:  patNext = {pat[0], pat[7:1]};
          BOUNCE: begin
            // Turn around at the ends so the end LEDs are never shown twice in a row.
            if (up) begin
              if (pos == 3'd7) begin
                upNext  = 1'b0;
                posNext = 3'd6;
              end else begin
                posNext = pos + 3'd1;
              end
            end else begin
              if (pos == 3'd0) begin
                upNext  = 1'b1;
                posNext = 3'd1;
              end else begin
                posNext = pos - 3'd1;
              end
            end
            patNext = 8'h01 << posNext;
          end
          COUNT:   patNext = pat + 8'd1;
          default: patNext = ~pat;
        endcase
      end
    end
  end

`ifdef DOM_ACTIVE_LOW_EN
  assign oLED = ~pat;
`else
  assign oLED = pat;
`endif

endmodule

// File: tb/tb_dom.sv
// Bench for dom: spec vectors, hand-written reset/hold sequences and random resets against a tick-count model.
module tb_dom;
  localparam int DIV = 4;
  localparam int STEPS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] led;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;  // edges since reset release

`ifdef DOM_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  dom #(.DIV(DIV), .STEPS(STEPS)) dut (.iCLK(clk), .iRST(rst), .oLED(led));

  always #10 clk = ~clk;

  // Expected LED value after k ticks, straight from the mode rules.
  function automatic logic [7:0] model(input int k);
    int m, s, p, q;
    logic [7:0] one, top, r;
    one = 8'h01;
    top = 8'h80;
    m = (k / STEPS) % 5;
    s = k % STEPS;
    case (m)
      0: r = one << (s % 8);
      1: r = top >> (s % 8);
      2: begin
        p = s % 14;
        q = (p <= 7) ? p : 14 - p;
        r = one << q;
      end
      3: r = 8'(s);
      default: r = (s % 2 == 0) ? 8'hAA : 8'h55;
    endcase
    return r ^ INV;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %02h expected %02h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock edge with the given reset level; output sampled 1 ns later.
  task automatic clkEdge(input logic r);
    rst = r;
    @(posedge clk);
    #1;
    cyc = r ? 0 : cyc + 1;
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) clkEdge(1'b1);
    rst = 1'b0;
  endtask

  typedef struct {
    int         ticks;
    logic [7:0] exp;
  } vecT;

  vecT vecs[$];

  initial begin
    vecs = '{
      '{0, 8'h01}, '{1, 8'h02}, '{2, 8'h04}, '{7, 8'h80}, '{8, 8'h01},
      '{16, 8'h80}, '{17, 8'h40}, '{32, 8'h01}, '{33, 8'h02}, '{39, 8'h80},
      '{40, 8'h40}, '{46, 8'h01}, '{47, 8'h02}, '{48, 8'h00}, '{49, 8'h01},
      '{63, 8'h0F}, '{64, 8'hAA}, '{65, 8'h55}, '{79, 8'h55}, '{80, 8'h01}
    };

    // Reset hold, then first change on the DIV-th edge after release.
    doReset(3);
    check("reset", led, 8'h01 ^ INV);
    for (int i = 0; i < DIV - 1; i++) begin
      clkEdge(1'b0);
      check("hold_after_reset", led, 8'h01 ^ INV);
    end
    clkEdge(1'b0);
    check("first_tick", led, 8'h02 ^ INV);

    // Spec vectors: reset, advance exactly ticks*DIV edges, compare.
    foreach (vecs[i]) begin
      doReset(1);
      for (int c = 0; c < vecs[i].ticks * DIV; c++) clkEdge(1'b0);
      check($sformatf("vec_tick%0d", vecs[i].ticks), led, vecs[i].exp ^ INV);
    end

    // Full sweep: every edge through one and a bit sequence, catches hold length.
    doReset(2);
    for (int c = 0; c < 90 * DIV; c++) begin
      clkEdge(1'b0);
      check("sweep", led, model(cyc / DIV));
    end

    // Reset mid-BLINK restarts at RUN_L and the prescaler restarts at 0.
    doReset(1);
    for (int c = 0; c < 70 * DIV + 2; c++) clkEdge(1'b0);
    check("pre_blink_reset", led, model(70));
    clkEdge(1'b1);
    check("blink_reset", led, 8'h01 ^ INV);
    for (int c = 0; c < DIV; c++) begin
      clkEdge(1'b0);
      check("post_blink_reset", led, model(cyc / DIV));
    end

    // Random reset pulses at random points, checked every edge.
    doReset(1);
    for (int it = 0; it < 3000; it++) begin
      clkEdge(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      check("random", led, (cyc == 0) ? (8'h01 ^ INV) : model(cyc / DIV));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
